axil_ctrl_regbank: RTL and testbench

AXIL_CTRL_REGBANK -- requirements
Module: axil_ctrl_regbank

---
 rtl/axil_ctrl_regbank.sv | 154 +++++++++++++++
 tb/tb_axil_ctrl_regbank.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ctrl_regbank.sv
`default_nettype none
// ============================================================================
// axil_ctrl_regbank : AXI4-Lite register bank with RW/RO registers and write strobes
// Revision 1.0 - initial release
// ============================================================================
module axil_ctrl_regbank #(
  parameter int                              C_S_AXI_DATA_WIDTH = 32,
  parameter int                              NUM_REGS           = 16,
  parameter int                              C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH/8),
  parameter logic [NUM_REGS-1:0]             RO_MASK            = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0]   RESET_VALUE        = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_ro_d,
  output logic [NUM_REGS-1:0]                      reg_wr_pulse
);

  localparam int         DW          = C_S_AXI_DATA_WIDTH;
  localparam int         SW          = DW / 8;
  localparam int         ADDR_LSB    = $clog2(SW);
  localparam int         IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                rdy_q;
  logic                aw_full_q;
  logic [IDX_W-1:0]    aw_idx_q;
  logic                w_full_q;
  logic [DW-1:0]       w_data_q;
  logic [SW-1:0]       w_strb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [DW-1:0]       rdata_q;
  logic [NUM_REGS-1:0] pulse_q;
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       ro_vals [NUM_REGS];

  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic [IDX_W-1:0] ar_idx;
  logic             unused_ok;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign reg_q[i*DW +: DW] = regs_q[i];
    assign ro_vals[i]        = reg_ro_d[i*DW +: DW];
  end

  // rdy_q keeps every READY low through reset and for the release edge itself
  assign S_AXI_AWREADY = rdy_q & ~aw_full_q;
  assign S_AXI_WREADY  = rdy_q & ~w_full_q;
  assign S_AXI_ARREADY = rdy_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign reg_wr_pulse  = pulse_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);
  assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdy_q     <= 1'b0;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      rdy_q   <= 1'b1;
      pulse_q <= '0;

      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end

      if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      // A commit on the same edge as a B handshake re-arms BVALID for the new response
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        if (RO_MASK[aw_idx_q]) begin
          bresp_q <= RESP_SLVERR;
        end else begin
          bresp_q           <= RESP_OKAY;
          pulse_q[aw_idx_q] <= 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (w_strb_q[b]) begin
              regs_q[aw_idx_q][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
          end
        end
      end

      if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= RO_MASK[ar_idx] ? ro_vals[ar_idx] : regs_q[ar_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_ctrl_regbank.sv
`default_nettype none
// Bench for axil_ctrl_regbank: directed AXI4-Lite scenarios plus random traffic
// checked against an array model of the register file.
module tb_axil_ctrl_regbank;

  logic        clk;
  logic        ARESETN;
  logic [5:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [5:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [511:0] reg_q;
  logic [511:0] reg_ro_d;
  logic [15:0]  reg_wr_pulse;

  axil_ctrl_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .NUM_REGS(16),
    .C_S_AXI_ADDR_WIDTH(6),
    .RO_MASK(16'h8000),
    .RESET_VALUE(32'h0)
  ) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .reg_ro_d(reg_ro_d), .reg_wr_pulse(reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] model [16];
  logic [31:0] ro15;
  int exp_pulse [16];
  int pulse_cnt [16];
  int reset_viol = 0;
  bit rst_sampled = 1'b0;

  always @(posedge clk) rst_sampled = (ARESETN === 1'b0);

  always @(negedge clk) begin
    if (ARESETN === 1'b1) begin
      for (int i = 0; i < 16; i++) if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    end
    if (rst_sampled && (S_AXI_BVALID === 1'b1 || S_AXI_RVALID === 1'b1 ||
                        S_AXI_AWREADY === 1'b1 || S_AXI_WREADY === 1'b1 ||
                        S_AXI_ARREADY === 1'b1 || (|reg_wr_pulse) === 1'b1))
      reset_viol++;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rq(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx == 15) return;
    model[idx] = merge(model[idx], d, s);
    exp_pulse[idx]++;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    return (idx == 15) ? ro15 : model[idx];
  endfunction

  // lead > 0: W offered that many cycles before AW; lead < 0: AW first
  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly, output logic [1:0] resp);
    int n, bw;
    bit aw_done, w_done, b_done, aw_hs, w_hs, b_hs;
    n = 0; bw = 0; aw_done = 0; w_done = 0; b_done = 0; resp = 2'bxx;
    S_AXI_AWADDR = 6'(idx*4 + int'($urandom_range(0, 3)));
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    S_AXI_BREADY = 1'b0;
    while (!b_done && n < 100) begin
      S_AXI_AWVALID = !aw_done && (n >= ((lead < 0) ? 0 : lead));
      S_AXI_WVALID  = !w_done && (n >= ((lead > 0) ? 0 : -lead));
      if (S_AXI_BVALID) begin
        if (bw >= bdly) S_AXI_BREADY = 1'b1;
        bw++;
      end
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      b_hs  = S_AXI_BVALID && S_AXI_BREADY;
      if (b_hs) resp = S_AXI_BRESP;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (b_hs) b_done = 1;
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    chk("wr_done", 32'(b_done), 32'd1);
  endtask

  task automatic axi_read(input int idx, input int rdly, output logic [31:0] d, output logic [1:0] rr);
    int n, rw;
    bit ar_done, r_done, ar_hs, r_hs, have_first;
    logic [31:0] first;
    n = 0; rw = 0; ar_done = 0; r_done = 0; have_first = 0; first = 'x; d = 'x; rr = 'x;
    S_AXI_ARADDR = 6'(idx*4 + int'($urandom_range(0, 3)));
    S_AXI_RREADY = 1'b0;
    while (!r_done && n < 100) begin
      S_AXI_ARVALID = !ar_done;
      if (S_AXI_RVALID) begin
        if (!have_first) begin first = S_AXI_RDATA; have_first = 1; end
        if (rw >= rdly) S_AXI_RREADY = 1'b1;
        rw++;
      end
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      r_hs  = S_AXI_RVALID && S_AXI_RREADY;
      if (r_hs) begin d = S_AXI_RDATA; rr = S_AXI_RRESP; end
      @(posedge clk); #1;
      if (ar_hs) ar_done = 1;
      if (r_hs) r_done = 1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    chk("rd_done", 32'(r_done), 32'd1);
    if (r_done) chk("rd_hold", d, first);
  endtask

  initial begin
    logic [1:0]  resp, rr;
    logic [31:0] rd, d, oldv;
    logic [3:0]  s;
    int snap [16];
    int idx, lead, dly;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < 16; i++) reg_ro_d[i*32 +: 32] = $urandom;
    ro15 = 32'hCAFE0001;
    reg_ro_d[15*32 +: 32] = ro15;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    repeat (20) @(posedge clk);
    #1;
    chk("rst_awready", 32'(S_AXI_AWREADY), 0);
    chk("rst_wready", 32'(S_AXI_WREADY), 0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_pulse", 32'(reg_wr_pulse), 0);
    chk("rst_reg3", rq(3), 0);
    chk("rst_valid_seen", 32'(reset_viol), 0);
    ARESETN = 1'b1;
    @(posedge clk); #1;
    chk("rdy_aw", 32'(S_AXI_AWREADY), 1);
    chk("rdy_w", 32'(S_AXI_WREADY), 1);
    chk("rdy_ar", 32'(S_AXI_ARREADY), 1);

    axi_read(3, 0, rd, rr);
    chk("rd_0c", rd, 32'h0);
    chk("rresp_0c", 32'(rr), 0);

    // Basic writes then read-back
    snap = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      axi_write(i, 32'(i + 1), 4'hF, 0, 0, resp);
      model_write(i, 32'(i + 1), 4'hF);
      chk("wr_bresp", 32'(resp), 0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(i, 0, rd, rr);
      chk("rd_back", rd, model[i]);
      chk("rd_rresp", 32'(rr), 0);
      chk("pulse_once", 32'(pulse_cnt[i] - snap[i]), 1);
    end

    // W three cycles ahead of AW
    snap = pulse_cnt;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_WVALID = 0;
    chk("wfirst_wready", 32'(S_AXI_WREADY), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("wfirst_nob", 32'(S_AXI_BVALID), 0);
    end
    S_AXI_AWADDR = 6'h14; S_AXI_AWVALID = 1; S_AXI_BREADY = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0;
    @(posedge clk); #1;
    model_write(5, 32'hDEADBEEF, 4'hF);
    chk("wfirst_bvalid", 32'(S_AXI_BVALID), 1);
    chk("wfirst_bresp", 32'(S_AXI_BRESP), 0);
    chk("wfirst_reg5", rq(5), model[5]);
    @(posedge clk); #1;
    S_AXI_BREADY = 0;
    chk("wfirst_bdone", 32'(S_AXI_BVALID), 0);
    chk("wfirst_pulse", 32'(pulse_cnt[5] - snap[5]), 1);

    // Byte strobes
    axi_write(2, 32'h11223344, 4'hF, 0, 0, resp);
    model_write(2, 32'h11223344, 4'hF);
    axi_write(2, 32'hAABBCCDD, 4'b0101, 1, 0, resp);
    model_write(2, 32'hAABBCCDD, 4'b0101);
    chk("strb_reg2", rq(2), model[2]);

    // Read-only target
    snap = pulse_cnt;
    axi_write(15, 32'h12345678, 4'hF, 0, 0, resp);
    chk("ro_bresp", 32'(resp), 32'h2);
    chk("ro_nopulse", 32'(pulse_cnt[15] - snap[15]), 0);
    axi_read(15, 0, rd, rr);
    chk("ro_read", rd, model_read(15));

    // B backpressure with a second write queued behind it
    S_AXI_AWADDR = 6'h18; S_AXI_WDATA = 32'hA5A50001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    @(posedge clk); #1;
    model_write(6, 32'hA5A50001, 4'hF);
    chk("bp_bvalid", 32'(S_AXI_BVALID), 1);
    chk("bp_reg6_a", rq(6), model[6]);
    S_AXI_WDATA = 32'h5A5A0002; S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("bp_awready", 32'(S_AXI_AWREADY), 0);
    chk("bp_wready", 32'(S_AXI_WREADY), 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_bhold", 32'(S_AXI_BVALID), 1);
      chk("bp_bresp", 32'(S_AXI_BRESP), 0);
      chk("bp_nocommit", rq(6), model[6]);
    end
    S_AXI_BREADY = 1;
    @(posedge clk); #1;
    model_write(6, 32'h5A5A0002, 4'hF);
    chk("bp_second", rq(6), model[6]);
    chk("bp_b2", 32'(S_AXI_BVALID), 1);
    @(posedge clk); #1;
    S_AXI_BREADY = 0;
    chk("bp_bclr", 32'(S_AXI_BVALID), 0);

    // R backpressure: RDATA holds while the RO source changes
    oldv = ro15;
    S_AXI_ARADDR = 6'h3C; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    @(posedge clk); #1;
    S_AXI_ARVALID = 0;
    chk("rbp_rvalid", 32'(S_AXI_RVALID), 1);
    chk("rbp_rdata", S_AXI_RDATA, oldv);
    ro15 = 32'h0BEEF000; reg_ro_d[15*32 +: 32] = ro15;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rbp_hold", S_AXI_RDATA, oldv);
      chk("rbp_arready", 32'(S_AXI_ARREADY), 0);
    end
    S_AXI_RREADY = 1;
    @(posedge clk); #1;
    S_AXI_RREADY = 0;
    chk("rbp_rclr", 32'(S_AXI_RVALID), 0);

    // Read sampled on the commit edge sees the old value
    axi_write(7, 32'h0BADF00D, 4'hF, 0, 0, resp);
    model_write(7, 32'h0BADF00D, 4'hF);
    oldv = model[7];
    S_AXI_AWADDR = 6'h1C; S_AXI_WDATA = 32'h600DCAFE; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARADDR = 6'h1C; S_AXI_ARVALID = 1; S_AXI_RREADY = 0; S_AXI_BREADY = 1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 0;
    model_write(7, 32'h600DCAFE, 4'hF);
    chk("rc_old", S_AXI_RDATA, oldv);
    chk("rc_rvalid", 32'(S_AXI_RVALID), 1);
    chk("rc_new", rq(7), model[7]);
    chk("rc_bvalid", 32'(S_AXI_BVALID), 1);
    @(posedge clk); #1;
    S_AXI_BREADY = 0; S_AXI_RREADY = 1;
    chk("rc_bclr", 32'(S_AXI_BVALID), 0);
    @(posedge clk); #1;
    S_AXI_RREADY = 0;
    chk("rc_rclr", 32'(S_AXI_RVALID), 0);

    // Random traffic against the model
    for (int t = 0; t < 160; t++) begin
      idx = int'($urandom_range(0, 15));
      dly = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        lead = int'($urandom_range(0, 6)) - 3;
        axi_write(idx, d, s, lead, dly, resp);
        model_write(idx, d, s);
        chk("rnd_bresp", 32'(resp), (idx == 15) ? 32'h2 : 32'h0);
        if (idx != 15) chk("rnd_regq", rq(idx), model[idx]);
      end else begin
        if (idx == 15) begin
          ro15 = $urandom;
          reg_ro_d[15*32 +: 32] = ro15;
        end
        axi_read(idx, dly, rd, rr);
        chk("rnd_rdata", rd, model_read(idx));
        chk("rnd_rresp", 32'(rr), 0);
      end
    end

    // Reset while a W is buffered and a read response is pending
    S_AXI_WDATA = 32'h55555555; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    @(posedge clk); #1;
    S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    chk("mr_rpend", 32'(S_AXI_RVALID), 1);
    ARESETN = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_bvalid", 32'(S_AXI_BVALID), 0);
    chk("mr_rvalid", 32'(S_AXI_RVALID), 0);
    chk("mr_viol", 32'(reset_viol), 0);
    for (int i = 0; i < 15; i++) model[i] = 32'h0;
    for (int i = 0; i < 15; i++) chk("mr_regs", rq(i), model[i]);
    ARESETN = 1;
    @(posedge clk); #1;
    axi_write(0, 32'h00000077, 4'hF, -6, 0, resp);
    model_write(0, 32'h00000077, 4'hF);
    chk("mr_reg0", rq(0), model[0]);

    for (int i = 0; i < 16; i++) chk("pulse_total", 32'(pulse_cnt[i]), 32'(exp_pulse[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
